// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8-bit UART receiver, optional even parity via UART_RX_PARITY_EN
// Frame: start + 8 data (LSB first) [+ even parity] + stop; decisions taken on synchronized rx only.
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_e;
`endif

  state_e          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [TW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q;
  logic            parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_valid_q <= 1'b0;
      if (baud_en) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q <= START;
              tick_q  <= '0;
            end
          end
          START: begin
            // Mid-start sample rejects glitches shorter than half a bit.
            if (tick_q == TICK_MID) begin
              if (rx_s_q) begin
                state_q <= IDLE;
              end else begin
                state_q <= DATA;
                tick_q  <= '0;
                bit_q   <= '0;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          DATA: begin
            if (tick_q == TICK_LAST) begin
              shift_q <= {rx_s_q, shift_q[7:1]};
              tick_q  <= '0;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_q == TICK_LAST) begin
              par_bad_q <= ^{shift_q, rx_s_q};
              tick_q    <= '0;
              state_q   <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_q == TICK_LAST) begin
              rx_data_q   <= shift_q;
              rx_valid_q  <= 1'b1;
              frame_err_q <= ~rx_s_q;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              tick_q      <= '0;
              state_q     <= IDLE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            tick_q  <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
